rx_scan_ctrl: RTL and testbench
===============================

// Module: rx_scan_ctrl
// PURPOSE
// - Sequencer for the rx move-finding datapath on one board square: latches the square's
//   piece, pulses collect_pieces, then walks direction_idx through every direction.
// - Forwards valid moves to the move stack and slide pieces to tx, stalling on backpressure.
// - Sits between the board-scan top level, the rx datapath, the move stack and tx.
// PARAMETERS
// - PIECE_W  10  piece encoding width (rx dest_piece / rx_tx_piece)
// - MOVE_W   16  formatted move width
// - CNT_W    5   move_count width; saturates at 2**CNT_W-1
// PORTS
// - clk              in   1        system clock, rising edge
// - rst              in   1        asynchronous, active-low reset (0 = reset)
// - start            in   1        begin a scan of one square; honoured only in IDLE
// - abort            in   1        cancel the scan; synchronous, wins over everything but rst
// - square_piece     in   PIECE_W  piece on the scanned square; sampled on an accepted start
// - rx_stack_write   in   1        from rx: current direction yields a legal move
// - rx_formatted_move in  MOVE_W   from rx: the move to push
// - rx_tx_valid      in   1        from rx: slide continues; pass the piece on to tx
// - rx_tx_piece      in   PIECE_W  from rx: piece to pass on
// - stack_full       in   1        move stack cannot accept a push this cycle
// - tx_ready         in   1        tx accepts tx_piece this cycle
// - collect_pieces   out  1        to rx: load the 16 neighbour registers
// - direction_idx    out  4        to rx: direction under test
// - dest_piece       out  PIECE_W  to rx: latched square_piece
// - stack_push       out  1        push stack_data this cycle
// - stack_data       out  MOVE_W   = rx_formatted_move
// - tx_valid         out  1        tx_piece valid
// - tx_piece         out  PIECE_W  = rx_tx_piece
// - busy             out  1        high in every state except IDLE
// - done             out  1        one-cycle pulse when the scan completes
// - move_count       out  CNT_W    moves pushed in the current or last scan
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0, including direction_idx, dest_piece and move_count.
// - IDLE: start=1 -> latch dest_piece, clear move_count, go to COLLECT.
// - COLLECT: exactly one cycle with collect_pieces=1 and direction_idx=0, then go to SCAN.
//   rx registers load on this edge, so the first SCAN cycle sees fresh data.
// - SCAN: one direction per cycle, stalling on backpressure.
//   - ok_s = !rx_stack_write | !stack_full
//   - ok_t = !rx_tx_valid | tx_ready
//   - adv  = ok_s & ok_t
//   - stack_push = rx_stack_write & adv
//   - tx_valid   = rx_tx_valid & ok_s  (never a function of tx_ready)
//   - Each move and each tx handshake therefore completes exactly once per direction.
//   - adv=0: hold direction_idx. adv=1 and dir != LAST_DIR: dir+1. adv=1 and dir == LAST_DIR: go to DONE.
// - DONE: done=1 for one cycle; dir returns to 0; go to IDLE. start in DONE is ignored.
// - stack_push, stack_data and tx_valid are forced to 0 outside SCAN.
// - move_count increments on each stack_push and saturates (no wrap).
//   It holds its value after DONE until the next accepted start.
// - start while busy: ignored.
// - abort=1 in any state: go to IDLE next cycle, dir=0. In that cycle stack_push=0 and tx_valid=0.
//   move_count is kept and done is not pulsed.
// - abort and start in the same cycle in IDLE: abort wins and start is dropped.
// - rst asserted mid-scan: immediate return to reset values; no partial push completes.
// - Latency with no stalls: start -> done = 1 (COLLECT) + N_DIR (SCAN) + 1 cycles.
//   This is 18 cycles with KNIGHT_SCAN_EN and 10 cycles without it.
// CONFIGURATION
// - KNIGHT_SCAN_EN defined: LAST_DIR=15; scans the 8 sliding directions then the 8 knight jumps.
// - KNIGHT_SCAN_EN undefined: LAST_DIR=7; direction_idx[3] is tied to 0 and knight logic is not built.
// STRUCTURE
// - Package rx_ctrl_pkg holds:
//   - state encoding IDLE/COLLECT/SCAN/DONE
//   - PIECE_W and MOVE_W defaults
//   - DIR_LAST_SLIDE=7, DIR_LAST_KNIGHT=15
// - Sub-module: none required. The saturating move_count may use a small sat_counter
//   instance if the team has one.
// TESTING
// - Free run, KNIGHT_SCAN_EN defined:
//   - start with stack_full=0, tx_ready=1, rx_stack_write=1 on dirs 0,5,9 -> 3 pushes, move_count=3.
//   - done asserts on cycle 18 after start.
// - Stack backpressure: stack_full=1 for 4 cycles while dir=2 and rx_stack_write=1.
//   - direction_idx holds at 2 and tx_valid=0.
//   - Exactly one push at dir 2 after stack_full falls.
// - tx backpressure: rx_tx_valid=1 at dir 1 and tx_ready=0 for 3 cycles.
//   - tx_valid stays high and tx_piece stays stable.
//   - One handshake, then dir advances to 2.
// - Abort at dir 6: next cycle IDLE, busy=0, no done pulse; a start 2 cycles later begins a clean scan.
// - Saturation with CNT_W=2 and rx_stack_write=1 every direction: move_count stops at 3.
// - Reset at dir 10: all outputs 0 asynchronously; a scan without KNIGHT_SCAN_EN never shows direction_idx > 7.

Source files
------------

// File: rtl/rx_scan_ctrl_pkg.sv
// Shared types and constants for the rx scan sequencer.
// KNIGHT_SCAN_EN selects the 16-direction walk (slides then knight jumps).
package rx_ctrl_pkg;

    localparam int PIECE_W_DEF = 10;
    localparam int MOVE_W_DEF  = 16;
    localparam int CNT_W_DEF   = 5;

    localparam logic [3:0] DIR_LAST_SLIDE  = 4'd7;
    localparam logic [3:0] DIR_LAST_KNIGHT = 4'd15;

`ifdef KNIGHT_SCAN_EN
    localparam int               DIR_W    = 4;
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_LAST_KNIGHT;
`else
    // Without knight jumps the top direction bit never exists in the register.
    localparam int               DIR_W    = 3;
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_LAST_SLIDE[DIR_W-1:0];
`endif

    localparam logic [DIR_W-1:0] DIR_ZERO = {DIR_W{1'b0}};
    localparam logic [DIR_W-1:0] DIR_ONE  = {{(DIR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SCAN    = 2'd2,
        ST_DONE    = 2'd3
    } scan_state_e;

endpackage

// File: rtl/rx_scan_ctrl_if.sv
// Datapath-facing bundle of the scan sequencer: rx control, move-stack push and tx forward.
// master = sequencer side, slave = rx/stack/tx side.
interface rx_scan_ctrl_if
    import rx_ctrl_pkg::*;
#(
    parameter int PIECE_W = PIECE_W_DEF,
    parameter int MOVE_W  = MOVE_W_DEF
) ();

    logic               collect_pieces;
    logic [3:0]         direction_idx;
    logic [PIECE_W-1:0] dest_piece;
    logic               stack_push;
    logic [MOVE_W-1:0]  stack_data;
    logic               tx_valid;
    logic [PIECE_W-1:0] tx_piece;

    logic               rx_stack_write;
    logic [MOVE_W-1:0]  rx_formatted_move;
    logic               rx_tx_valid;
    logic [PIECE_W-1:0] rx_tx_piece;
    logic               stack_full;
    logic               tx_ready;

    modport master (
        output collect_pieces, direction_idx, dest_piece,
        output stack_push, stack_data, tx_valid, tx_piece,
        input  rx_stack_write, rx_formatted_move, rx_tx_valid, rx_tx_piece,
        input  stack_full, tx_ready
    );

    modport slave (
        input  collect_pieces, direction_idx, dest_piece,
        input  stack_push, stack_data, tx_valid, tx_piece,
        output rx_stack_write, rx_formatted_move, rx_tx_valid, rx_tx_piece,
        output stack_full, tx_ready
    );

endinterface

// File: rtl/rx_scan_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module rx_scan_ctrl_sat_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_r;

    // Count register: clear wins over increment, increment stops at the ceiling
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/rx_scan_ctrl.sv
// rx_scan_ctrl: per-square sequencer for the rx move-finding datapath.
// KNIGHT_SCAN_EN extends the direction walk from the 8 slides to the 8 knight jumps.
module rx_scan_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int PIECE_W = PIECE_W_DEF,
    parameter int MOVE_W  = MOVE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [PIECE_W-1:0] square_piece,
    rx_scan_ctrl_if.master     bus,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   move_count
);

    scan_state_e        state_r;
    scan_state_e        state_s;
    logic [DIR_W-1:0]   dir_r;
    logic [DIR_W-1:0]   dir_s;
    logic [PIECE_W-1:0] dest_r;
    logic               accept_s;
    logic               scan_s;
    logic               ok_stk_s;
    logic               ok_tx_s;
    logic               adv_s;
    logic               push_s;
    logic               txv_s;

    // State and direction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            dir_r   <= DIR_ZERO;
        end else begin
            state_r <= state_s;
            dir_r   <= dir_s;
        end
    end

    // Square piece capture on an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_r <= {PIECE_W{1'b0}};
        end else if (accept_s) begin
            dest_r <= square_piece;
        end else begin
            dest_r <= dest_r;
        end
    end

    // Next-state decode and handshake qualification; abort overrides every state
    always_comb begin
        state_s  = state_r;
        dir_s    = dir_r;
        accept_s = 1'b0;
        scan_s   = 1'b0;
        adv_s    = 1'b0;
        push_s   = 1'b0;
        txv_s    = 1'b0;
        ok_stk_s = !bus.rx_stack_write || !bus.stack_full;
        ok_tx_s  = !bus.rx_tx_valid || bus.tx_ready;
        if (abort) begin
            state_s = ST_IDLE;
            dir_s   = DIR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        accept_s = 1'b1;
                        state_s  = ST_COLLECT;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                    dir_s = DIR_ZERO;
                end
                ST_COLLECT: begin
                    state_s = ST_SCAN;
                    dir_s   = DIR_ZERO;
                end
                ST_SCAN: begin
                    // tx_valid ignores tx_ready so the tx side never sees a combinational loop
                    scan_s = 1'b1;
                    adv_s  = ok_stk_s && ok_tx_s;
                    push_s = bus.rx_stack_write && adv_s;
                    txv_s  = bus.rx_tx_valid && ok_stk_s;
                    if (!adv_s) begin
                        dir_s = dir_r;
                    end else if (dir_r == DIR_LAST) begin
                        state_s = ST_DONE;
                        dir_s   = DIR_ZERO;
                    end else begin
                        dir_s = dir_r + DIR_ONE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    dir_s   = DIR_ZERO;
                end
                default: begin
                    state_s = ST_IDLE;
                    dir_s   = DIR_ZERO;
                end
            endcase
        end
    end

`ifdef KNIGHT_SCAN_EN
    assign bus.direction_idx = dir_r;
`else
    assign bus.direction_idx = {1'b0, dir_r};
`endif

    assign bus.collect_pieces = (state_r == ST_COLLECT);
    assign bus.dest_piece     = dest_r;
    assign bus.stack_push     = push_s;
    assign bus.stack_data     = scan_s ? bus.rx_formatted_move : {MOVE_W{1'b0}};
    assign bus.tx_valid       = txv_s;
    assign bus.tx_piece       = scan_s ? bus.rx_tx_piece : {PIECE_W{1'b0}};
    assign busy               = (state_r != ST_IDLE);
    assign done               = (state_r == ST_DONE) && !abort;

    rx_scan_ctrl_sat_cnt #(
        .W (CNT_W)
    ) u_move_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_s),
        .inc   (push_s),
        .count (move_count)
    );

endmodule

// File: tb/tb_rx_scan_ctrl.sv
// Directed bench for rx_scan_ctrl; expectations adapt to whether KNIGHT_SCAN_EN is defined.
`timescale 1ns/1ps
module tb_rx_scan_ctrl;

    localparam int PW = 10;
    localparam int MW = 16;
    localparam int CW = 5;
`ifdef KNIGHT_SCAN_EN
    localparam int LAST = 15;
`else
    localparam int LAST = 7;
`endif
    localparam int RST_DIR = (LAST > 10) ? 10 : (LAST - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] square_piece = 10'h000;
    logic [15:0]   wr_mask = 16'h0000;
    logic [15:0]   txv_mask = 16'h0000;
    logic          stack_full = 1'b0;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [CW-1:0] move_count;

    logic          start2 = 1'b0;
    logic          abort2 = 1'b0;
    logic          busy2;
    logic          done2;
    logic [1:0]    cnt2;

    int errors = 0;
    int checks = 0;
    int push_total = 0;
    logic [3:0] max_dir = 4'd0;

    always #5 clk = ~clk;

    rx_scan_ctrl_if #(.PIECE_W(PW), .MOVE_W(MW)) bus ();
    assign bus.rx_stack_write    = wr_mask[bus.direction_idx];
    assign bus.rx_tx_valid       = txv_mask[bus.direction_idx];
    assign bus.rx_formatted_move = {12'hA50, bus.direction_idx};
    assign bus.rx_tx_piece       = {6'h2A, bus.direction_idx};
    assign bus.stack_full        = stack_full;
    assign bus.tx_ready          = tx_ready;

    rx_scan_ctrl #(.PIECE_W(PW), .MOVE_W(MW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .square_piece(square_piece),
        .bus(bus.master), .busy(busy), .done(done), .move_count(move_count)
    );

    rx_scan_ctrl_if bus2 ();
    assign bus2.rx_stack_write    = 1'b1;
    assign bus2.rx_formatted_move = 16'h0000;
    assign bus2.rx_tx_valid       = 1'b0;
    assign bus2.rx_tx_piece       = 10'h000;
    assign bus2.stack_full        = 1'b0;
    assign bus2.tx_ready          = 1'b1;

    rx_scan_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .square_piece(10'h001),
        .bus(bus2.master), .busy(busy2), .done(done2), .move_count(cnt2)
    );

    always @(negedge clk) begin
        if (bus.stack_push) push_total <= push_total + 1;
        if (bus.direction_idx > max_dir) max_dir <= bus.direction_idx;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PW-1:0] p);
        square_piece = p;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic run_to_dir(input logic [3:0] d);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (busy && !bus.collect_pieces && !done && bus.direction_idx == d) hit = 1'b1;
            else tick;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL run_to_dir: direction %0d never reached", d); end
    endtask

    task automatic wait_done;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (done) hit = 1'b1;
            else tick;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL wait_done: done not seen within 40 cycles"); end
    endtask

    task automatic test_reset;
        wr_mask = 16'hFFFF; txv_mask = 16'hFFFF; start = 1'b1; square_piece = 10'h3FF;
        tick; tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (bus.collect_pieces !== 1'b0) begin errors++; $display("FAIL reset_collect: got %0b want 0", bus.collect_pieces); end
        checks++; if (bus.direction_idx !== 4'd0) begin errors++; $display("FAIL reset_dir: got %0d want 0", bus.direction_idx); end
        checks++; if (bus.dest_piece !== 10'h000) begin errors++; $display("FAIL reset_dest: got %0h want 0", bus.dest_piece); end
        checks++; if (bus.stack_push !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_push_tx: got push=%0b tx=%0b want 0 0", bus.stack_push, bus.tx_valid); end
        checks++; if (move_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", move_count); end
        start = 1'b0; rst = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %0b want 0", busy); end
    endtask

    task automatic test_free_run;
        int base, done_at, done_cnt, exp;
        exp = (LAST >= 9) ? 3 : 2;
        wr_mask = 16'h0221; txv_mask = 16'h0000; stack_full = 1'b0; tx_ready = 1'b1;
        base = push_total; done_at = 0; done_cnt = 0;
        square_piece = 10'h155; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick;
            start = 1'b0;
            if (k == 1) begin
                checks++; if (bus.collect_pieces !== 1'b1 || bus.direction_idx !== 4'd0) begin errors++; $display("FAIL free_collect: got collect=%0b dir=%0d want 1 0", bus.collect_pieces, bus.direction_idx); end
                checks++; if (bus.dest_piece !== 10'h155) begin errors++; $display("FAIL free_dest: got %0h want 155", bus.dest_piece); end
                checks++; if (busy !== 1'b1 || move_count !== 5'd0) begin errors++; $display("FAIL free_busy_count: got busy=%0b count=%0d want 1 0", busy, move_count); end
            end
            if (bus.stack_push) begin
                checks++; if (bus.stack_data !== {12'hA50, bus.direction_idx}) begin errors++; $display("FAIL free_data: got %0h want %0h", bus.stack_data, {12'hA50, bus.direction_idx}); end
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
        checks++; if (done_at !== LAST + 3) begin errors++; $display("FAIL free_latency: got %0d want %0d", done_at, LAST + 3); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL free_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (push_total - base !== exp) begin errors++; $display("FAIL free_pushes: got %0d want %0d", push_total - base, exp); end
        checks++; if (int'(move_count) !== exp || busy !== 1'b0) begin errors++; $display("FAIL free_count_hold: got count=%0d busy=%0b want %0d 0", move_count, busy, exp); end
    endtask

    task automatic test_stack_backpressure;
        int base;
        wr_mask = 16'h0004; txv_mask = 16'h0004; stack_full = 1'b1; tx_ready = 1'b1;
        base = push_total;
        do_start(10'h011);
        checks++; if (move_count !== 5'd0) begin errors++; $display("FAIL stk_count_clear: got %0d want 0", move_count); end
        run_to_dir(4'd2);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.direction_idx !== 4'd2 || bus.stack_push !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL stk_hold: cycle %0d got dir=%0d push=%0b tx=%0b want 2 0 0", i, bus.direction_idx, bus.stack_push, bus.tx_valid); end
            if (i < 3) tick;
        end
        stack_full = 1'b0;
        #1;
        checks++; if (bus.stack_push !== 1'b1 || bus.tx_valid !== 1'b1 || bus.stack_data !== 16'hA502) begin errors++; $display("FAIL stk_release: got push=%0b tx=%0b data=%0h want 1 1 a502", bus.stack_push, bus.tx_valid, bus.stack_data); end
        tick;
        checks++; if (bus.direction_idx !== 4'd3 || bus.stack_push !== 1'b0) begin errors++; $display("FAIL stk_advance: got dir=%0d push=%0b want 3 0", bus.direction_idx, bus.stack_push); end
        wait_done;
        checks++; if (push_total - base !== 1 || move_count !== 5'd1) begin errors++; $display("FAIL stk_once: got pushes=%0d count=%0d want 1 1", push_total - base, move_count); end
        tick;
    endtask

    task automatic test_tx_backpressure;
        wr_mask = 16'h0000; txv_mask = 16'h0002; stack_full = 1'b0; tx_ready = 1'b0;
        do_start(10'h022);
        run_to_dir(4'd1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.tx_valid !== 1'b1 || bus.tx_piece !== 10'h2A1 || bus.direction_idx !== 4'd1) begin errors++; $display("FAIL tx_hold: cycle %0d got valid=%0b piece=%0h dir=%0d want 1 2a1 1", i, bus.tx_valid, bus.tx_piece, bus.direction_idx); end
            if (i < 2) tick;
        end
        tx_ready = 1'b1;
        #1;
        checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL tx_handshake: got valid=%0b want 1", bus.tx_valid); end
        tick;
        checks++; if (bus.direction_idx !== 4'd2 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_advance: got dir=%0d valid=%0b want 2 0", bus.direction_idx, bus.tx_valid); end
        wait_done;
        tick;
    endtask

    task automatic test_abort;
        int cyc;
        wr_mask = 16'h0048; txv_mask = 16'h0040; stack_full = 1'b0; tx_ready = 1'b1;
        do_start(10'h033);
        run_to_dir(4'd6);
        checks++; if (bus.stack_push !== 1'b1) begin errors++; $display("FAIL abort_pre_push: got %0b want 1", bus.stack_push); end
        abort = 1'b1;
        #1;
        checks++; if (bus.stack_push !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL abort_gate: got push=%0b tx=%0b want 0 0", bus.stack_push, bus.tx_valid); end
        tick;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.direction_idx !== 4'd0) begin errors++; $display("FAIL abort_idle: got busy=%0b done=%0b dir=%0d want 0 0 0", busy, done, bus.direction_idx); end
        checks++; if (move_count !== 5'd1) begin errors++; $display("FAIL abort_count_kept: got %0d want 1", move_count); end
        tick;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done=%0b busy=%0b want 0 0", done, busy); end
        do_start(10'h044);
        checks++; if (bus.collect_pieces !== 1'b1 || move_count !== 5'd0 || bus.dest_piece !== 10'h044) begin errors++; $display("FAIL abort_restart: got collect=%0b count=%0d dest=%0h want 1 0 44", bus.collect_pieces, move_count, bus.dest_piece); end
        cyc = 1;
        for (int i = 0; i < 40 && !done; i++) begin tick; cyc++; end
        checks++; if (cyc !== LAST + 3) begin errors++; $display("FAIL abort_clean_latency: got %0d want %0d", cyc, LAST + 3); end
        checks++; if (move_count !== 5'd2) begin errors++; $display("FAIL abort_clean_count: got %0d want 2", move_count); end
        tick;
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || bus.collect_pieces !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got busy=%0b collect=%0b want 0 0", busy, bus.collect_pieces); end
    endtask

    task automatic test_start_ignored;
        wr_mask = 16'h0000; txv_mask = 16'h0000;
        do_start(10'h0AA);
        tick; tick;
        square_piece = 10'h3FF; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (bus.dest_piece !== 10'h0AA || bus.collect_pieces !== 1'b0 || bus.direction_idx !== 4'd2) begin errors++; $display("FAIL busy_start: got dest=%0h collect=%0b dir=%0d want aa 0 2", bus.dest_piece, bus.collect_pieces, bus.direction_idx); end
        wait_done;
        start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || bus.collect_pieces !== 1'b0) begin errors++; $display("FAIL done_start: got busy=%0b collect=%0b want 0 0", busy, bus.collect_pieces); end
    endtask

    task automatic test_saturation;
        wr_mask = 16'hFFFF; txv_mask = 16'h0000;
        square_piece = 10'h055; start = 1'b1; start2 = 1'b1;
        tick;
        start = 1'b0; start2 = 1'b0;
        wait_done;
        checks++; if (done2 !== 1'b1 || cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2: got done=%0b count=%0d want 1 3", done2, cnt2); end
        checks++; if (int'(move_count) !== LAST + 1) begin errors++; $display("FAIL sat_full_count: got %0d want %0d", move_count, LAST + 1); end
        tick;
        checks++; if (cnt2 !== 2'd3 || busy2 !== 1'b0) begin errors++; $display("FAIL sat_hold: got count=%0d busy=%0b want 3 0", cnt2, busy2); end
    endtask

    task automatic test_reset_mid;
        wr_mask = 16'hFFFF; txv_mask = 16'hFFFF;
        do_start(10'h2C3);
        run_to_dir(4'(RST_DIR));
        checks++; if (bus.stack_push !== 1'b1 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got push=%0b tx=%0b want 1 1", bus.stack_push, bus.tx_valid); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.direction_idx !== 4'd0 || bus.dest_piece !== 10'h000) begin errors++; $display("FAIL rstmid_state: got busy=%0b done=%0b dir=%0d dest=%0h want 0 0 0 0", busy, done, bus.direction_idx, bus.dest_piece); end
        checks++; if (bus.stack_push !== 1'b0 || bus.tx_valid !== 1'b0 || bus.stack_data !== 16'h0000 || bus.tx_piece !== 10'h000) begin errors++; $display("FAIL rstmid_bus: got push=%0b tx=%0b data=%0h piece=%0h want 0 0 0 0", bus.stack_push, bus.tx_valid, bus.stack_data, bus.tx_piece); end
        checks++; if (move_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", move_count); end
        tick;
        rst = 1'b1;
        tick;
        wr_mask = 16'h0000; txv_mask = 16'h0000;
        do_start(10'h001);
        wait_done;
        tick;
        checks++; if (int'(max_dir) > LAST) begin errors++; $display("FAIL max_dir: got %0d want <= %0d", max_dir, LAST); end
    endtask

    initial begin
        test_reset;
        test_free_run;
        tick; tick; tick;
        test_stack_backpressure;
        test_tx_backpressure;
        test_abort;
        tick;
        test_start_ignored;
        tick;
        test_saturation;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
